frame_stream_arb: RTL and testbench

- Two-requester, frame-granular round-robin arbiter that shares one 32-bit sof/eof stream path between two 32-bit video/data sources.
- Its master port feeds the 32-to-16 downconverter (which in turn feeds the 16-bit SPI/display path).
- Grants are held for a whole frame (sof to eof) so frames never interleave.
- Also provides per-source enables, orphan-beat dropping and frame/drop counters for CSR readback.

---
 rtl/frame_stream_arb.sv | 153 +++++++++++++++
 tb/tb_frame_stream_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_arb.sv
// frame_stream_arb
// Two-source, frame-granular round-robin arbiter. Sources 0 and 1 share one
// 32-bit sof/eof stream path toward the 32-to-16 downconverter. A grant is
// taken on a sof beat and held until the granted source's eof handshake, so
// frames never interleave. In IDLE, beats that arrive without sof from an
// enabled source are treated as orphans: they are acknowledged, discarded
// and counted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   src_en[1:0]         per-source enable for new grants and orphan dropping
//   s0_* / s1_*         source streams (data, sof, eof, vld in, rdy out)
//   m_*                 muxed master stream (data, sof, eof, vld out, rdy in)
//   busy                a grant is held
//   grant[1:0]          one-hot current grant, 00 in IDLE
//   frame_cnt0/1        completed frames per source (wrapping)
//   drop_cnt            orphan beats discarded, both sources (wrapping)
module frame_stream_arb #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    src_en,
  input  logic [DW-1:0] s0_data_i,
  input  logic          s0_sof,
  input  logic          s0_eof,
  input  logic          s0_vld_i,
  output logic          s0_rdy_o,
  input  logic [DW-1:0] s1_data_i,
  input  logic          s1_sof,
  input  logic          s1_eof,
  input  logic          s1_vld_i,
  output logic          s1_rdy_o,
  output logic [DW-1:0] m_data_o,
  output logic          m_sof,
  output logic          m_eof,
  output logic          m_vld_o,
  input  logic          m_rdy_i,
  output logic          busy,
  output logic [1:0]    grant,
  output logic [CW-1:0] frame_cnt0,
  output logic [CW-1:0] frame_cnt1,
  output logic [CW-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state, state_nxt;
  // rr_last names the source that most recently completed a frame; on a tie
  // the other source wins. Reset value 1 lets source 0 win the first tie.
  logic   rr_last, rr_last_nxt;
  logic   req0, req1;
  logic   drop0, drop1;
  logic   fend0, fend1;
  logic   rdy0_c, rdy1_c;

  assign req0 = src_en[0] & s0_vld_i & s0_sof;
  assign req1 = src_en[1] & s1_vld_i & s1_sof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    m_data_o    = '0;
    m_sof       = 1'b0;
    m_eof       = 1'b0;
    m_vld_o     = 1'b0;
    rdy0_c      = 1'b0;
    rdy1_c      = 1'b0;
    busy        = 1'b0;
    grant       = 2'b00;
    drop0       = 1'b0;
    drop1       = 1'b0;
    fend0       = 1'b0;
    fend1       = 1'b0;
    case (state)
      IDLE: begin
        // Requesters see rdy=0 so the sof beat is held for the grant cycle.
        drop0  = src_en[0] & s0_vld_i & ~s0_sof;
        drop1  = src_en[1] & s1_vld_i & ~s1_sof;
        rdy0_c = drop0;
        rdy1_c = drop1;
        if (req0 && req1)
          state_nxt = rr_last ? G0 : G1;
        else if (req0)
          state_nxt = G0;
        else if (req1)
          state_nxt = G1;
      end
      G0: begin
        m_data_o = s0_data_i;
        m_sof    = s0_sof;
        m_eof    = s0_eof;
        m_vld_o  = s0_vld_i;
        rdy0_c   = m_rdy_i;
        busy     = 1'b1;
        grant    = 2'b01;
        if (s0_vld_i && m_rdy_i && s0_eof) begin
          fend0       = 1'b1;
          state_nxt   = IDLE;
          rr_last_nxt = 1'b0;
        end
      end
      G1: begin
        m_data_o = s1_data_i;
        m_sof    = s1_sof;
        m_eof    = s1_eof;
        m_vld_o  = s1_vld_i;
        rdy1_c   = m_rdy_i;
        busy     = 1'b1;
        grant    = 2'b10;
        if (s1_vld_i && m_rdy_i && s1_eof) begin
          fend1       = 1'b1;
          state_nxt   = IDLE;
          rr_last_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While rst is held the state already reads IDLE, but orphan acks must
  // also be suppressed so no beat is consumed during reset.
  assign s0_rdy_o = rdy0_c & ~rst;
  assign s1_rdy_o = rdy1_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      drop_cnt   <= '0;
    end else begin
      frame_cnt0 <= frame_cnt0 + CW'(fend0);
      frame_cnt1 <= frame_cnt1 + CW'(fend1);
      drop_cnt   <= drop_cnt + CW'(drop0) + CW'(drop1);
    end
  end

endmodule

// File: tb/tb_frame_stream_arb.sv
module tb_frame_stream_arb;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    src_en;
  logic [DW-1:0] s0_data_i, s1_data_i;
  logic          s0_sof, s0_eof, s0_vld_i, s0_rdy_o;
  logic          s1_sof, s1_eof, s1_vld_i, s1_rdy_o;
  logic [DW-1:0] m_data_o;
  logic          m_sof, m_eof, m_vld_o, m_rdy_i;
  logic          busy;
  logic [1:0]    grant;
  logic [CW-1:0] frame_cnt0, frame_cnt1, drop_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  frame_stream_arb #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .src_en(src_en),
    .s0_data_i(s0_data_i), .s0_sof(s0_sof), .s0_eof(s0_eof),
    .s0_vld_i(s0_vld_i), .s0_rdy_o(s0_rdy_o),
    .s1_data_i(s1_data_i), .s1_sof(s1_sof), .s1_eof(s1_eof),
    .s1_vld_i(s1_vld_i), .s1_rdy_o(s1_rdy_o),
    .m_data_o(m_data_o), .m_sof(m_sof), .m_eof(m_eof),
    .m_vld_o(m_vld_o), .m_rdy_i(m_rdy_i),
    .busy(busy), .grant(grant),
    .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; leaves time 2 units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    s0_vld_i = 1'b0; s0_sof = 1'b0; s0_eof = 1'b0; s0_data_i = '0;
    s1_vld_i = 1'b0; s1_sof = 1'b0; s1_eof = 1'b0; s1_data_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    src_en  = 2'b11;
    m_rdy_i = 1'b1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_en = 2'b11;
    m_rdy_i = 1'b1;
    idle_inputs();
    s0_vld_i = 1'b1; s0_data_i = 32'hDEAD_BEEF;  // orphan-shaped beat during reset
    #3;
    vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL reset_grant got %b exp 00", grant); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b exp 0", busy); end
    vec_cnt++; if (m_vld_o !== 1'b0 || m_sof !== 1'b0 || m_eof !== 1'b0) begin err_cnt++; $display("FAIL reset_mctl got vld=%b sof=%b eof=%b exp 0", m_vld_o, m_sof, m_eof); end
    vec_cnt++; if (m_data_o !== 32'h0) begin err_cnt++; $display("FAIL reset_mdata got %h exp 0", m_data_o); end
    vec_cnt++; if ({s0_rdy_o, s1_rdy_o} !== 2'b00) begin err_cnt++; $display("FAIL reset_rdy got %b exp 00", {s0_rdy_o, s1_rdy_o}); end
    vec_cnt++; if ({frame_cnt0, frame_cnt1, drop_cnt} !== 12'h000) begin err_cnt++; $display("FAIL reset_cnts got %h exp 000", {frame_cnt0, frame_cnt1, drop_cnt}); end
    idle_inputs();
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    logic [31:0] d [4];
    d[0] = 32'hA000_0000; d[1] = 32'hA111_1111; d[2] = 32'hA222_2222; d[3] = 32'hA333_3333;
    s0_vld_i = 1'b1; s0_sof = 1'b1; s0_data_i = d[0];
    #1;
    vec_cnt++; if (grant !== 2'b00 || s0_rdy_o !== 1'b0) begin err_cnt++; $display("FAIL single_arb got grant=%b rdy=%b exp 00/0", grant, s0_rdy_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      s0_data_i = d[i]; s0_sof = (i == 0); s0_eof = (i == 3);
      if (i == 1) src_en = 2'b10;  // disabling mid-frame must not cut the grant
      #1;
      vec_cnt++; if (grant !== 2'b01 || busy !== 1'b1) begin err_cnt++; $display("FAIL single_grant beat %0d got grant=%b busy=%b exp 01/1", i, grant, busy); end
      vec_cnt++; if (m_data_o !== d[i] || m_vld_o !== 1'b1 || s0_rdy_o !== 1'b1) begin err_cnt++; $display("FAIL single_data beat %0d got %h vld=%b rdy=%b exp %h/1/1", i, m_data_o, m_vld_o, s0_rdy_o, d[i]); end
      vec_cnt++; if (m_sof !== (i == 0) || m_eof !== (i == 3)) begin err_cnt++; $display("FAIL single_sofeof beat %0d got %b%b", i, m_sof, m_eof); end
      tick();
    end
    idle_inputs();
    src_en = 2'b11;
    #1;
    vec_cnt++; if (grant !== 2'b00 || busy !== 1'b0) begin err_cnt++; $display("FAIL single_idle got grant=%b busy=%b exp 00/0", grant, busy); end
    vec_cnt++; if (frame_cnt0 !== 4'd1 || drop_cnt !== 4'd0) begin err_cnt++; $display("FAIL single_cnts got f0=%0d drop=%0d exp 1/0", frame_cnt0, drop_cnt); end
  endtask

  task automatic test_both_requests();
    do_reset();
    s0_vld_i = 1'b1; s0_sof = 1'b1; s0_data_i = 32'hB000_0000;
    s1_vld_i = 1'b1; s1_sof = 1'b1; s1_data_i = 32'hC000_0000;
    #1;
    vec_cnt++; if ({s0_rdy_o, s1_rdy_o} !== 2'b00) begin err_cnt++; $display("FAIL both_arb_rdy got %b exp 00", {s0_rdy_o, s1_rdy_o}); end
    tick();
    #1;
    vec_cnt++; if (grant !== 2'b01 || s1_rdy_o !== 1'b0 || m_data_o !== 32'hB000_0000) begin err_cnt++; $display("FAIL both_first got grant=%b s1rdy=%b data=%h exp 01/0/b0000000", grant, s1_rdy_o, m_data_o); end
    tick();
    s0_sof = 1'b0; s0_eof = 1'b1; s0_data_i = 32'hB000_0001;
    #1;
    vec_cnt++; if (m_data_o !== 32'hB000_0001 || s1_rdy_o !== 1'b0) begin err_cnt++; $display("FAIL both_s0eof got data=%h s1rdy=%b exp b0000001/0", m_data_o, s1_rdy_o); end
    tick();
    s0_vld_i = 1'b0; s0_sof = 1'b0; s0_eof = 1'b0;
    #1;
    vec_cnt++; if (grant !== 2'b00 || s1_rdy_o !== 1'b0 || frame_cnt0 !== 4'd1) begin err_cnt++; $display("FAIL both_bubble got grant=%b s1rdy=%b f0=%0d exp 00/0/1", grant, s1_rdy_o, frame_cnt0); end
    tick();
    #1;
    vec_cnt++; if (grant !== 2'b10 || m_data_o !== 32'hC000_0000 || s1_rdy_o !== 1'b1) begin err_cnt++; $display("FAIL both_second got grant=%b data=%h rdy=%b exp 10/c0000000/1", grant, m_data_o, s1_rdy_o); end
    tick();
    s1_sof = 1'b0; s1_eof = 1'b1; s1_data_i = 32'hC000_0001;
    tick();
    s1_vld_i = 1'b0; s1_eof = 1'b0;
    #1;
    vec_cnt++; if (frame_cnt0 !== 4'd1 || frame_cnt1 !== 4'd1 || grant !== 2'b00) begin err_cnt++; $display("FAIL both_cnts got f0=%0d f1=%0d grant=%b exp 1/1/00", frame_cnt0, frame_cnt1, grant); end
    // s1 finished last, so a fresh tie goes to s0.
    s0_vld_i = 1'b1; s0_sof = 1'b1; s1_vld_i = 1'b1; s1_sof = 1'b1;
    tick();
    #1;
    vec_cnt++; if (grant !== 2'b01) begin err_cnt++; $display("FAIL both_rrlast got grant=%b exp 01", grant); end
  endtask

  task automatic test_backpressure();
    do_reset();
    s1_vld_i = 1'b1; s1_sof = 1'b1; s1_data_i = 32'h1111_0000;
    tick();
    m_rdy_i = 1'b1;
    #1;
    vec_cnt++; if (s1_rdy_o !== 1'b1 || m_data_o !== 32'h1111_0000) begin err_cnt++; $display("FAIL bp_b0 got rdy=%b data=%h exp 1/11110000", s1_rdy_o, m_data_o); end
    tick();
    s1_sof = 1'b0; s1_data_i = 32'h1111_0001; m_rdy_i = 1'b0;
    #1;
    vec_cnt++; if (s1_rdy_o !== 1'b0 || m_data_o !== 32'h1111_0001 || m_vld_o !== 1'b1) begin err_cnt++; $display("FAIL bp_stall1 got rdy=%b data=%h vld=%b exp 0/11110001/1", s1_rdy_o, m_data_o, m_vld_o); end
    tick();
    #1;
    vec_cnt++; if (s1_rdy_o !== 1'b0 || m_data_o !== 32'h1111_0001 || grant !== 2'b10) begin err_cnt++; $display("FAIL bp_stall2 got rdy=%b data=%h grant=%b exp 0/11110001/10", s1_rdy_o, m_data_o, grant); end
    tick();
    m_rdy_i = 1'b1;
    #1;
    vec_cnt++; if (s1_rdy_o !== 1'b1 || m_data_o !== 32'h1111_0001 || m_eof !== 1'b0) begin err_cnt++; $display("FAIL bp_resume got rdy=%b data=%h eof=%b exp 1/11110001/0", s1_rdy_o, m_data_o, m_eof); end
    tick();
    s1_eof = 1'b1; s1_data_i = 32'h1111_0002;
    #1;
    vec_cnt++; if (m_eof !== 1'b1 || m_data_o !== 32'h1111_0002 || s1_rdy_o !== 1'b1) begin err_cnt++; $display("FAIL bp_eof got eof=%b data=%h rdy=%b exp 1/11110002/1", m_eof, m_data_o, s1_rdy_o); end
    tick();
    idle_inputs();
    #1;
    vec_cnt++; if (grant !== 2'b00 || frame_cnt1 !== 4'd1 || frame_cnt0 !== 4'd0) begin err_cnt++; $display("FAIL bp_done got grant=%b f1=%0d f0=%0d exp 00/1/0", grant, frame_cnt1, frame_cnt0); end
  endtask

  task automatic test_orphans();
    do_reset();
    src_en = 2'b01;
    s1_vld_i = 1'b1; s1_sof = 1'b1; s1_data_i = 32'h5555_5555;
    s0_vld_i = 1'b1; s0_sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s0_data_i = 32'h0E00_0000 + i;
      #1;
      vec_cnt++; if (s0_rdy_o !== 1'b1 || s1_rdy_o !== 1'b0 || m_vld_o !== 1'b0) begin err_cnt++; $display("FAIL orphan_ack %0d got s0rdy=%b s1rdy=%b vld=%b exp 1/0/0", i, s0_rdy_o, s1_rdy_o, m_vld_o); end
      tick();
    end
    s0_sof = 1'b1; s0_eof = 1'b1; s0_data_i = 32'h0F00_0000;
    #1;
    vec_cnt++; if (drop_cnt !== 4'd3 || s0_rdy_o !== 1'b0) begin err_cnt++; $display("FAIL orphan_cnt got drop=%0d s0rdy=%b exp 3/0", drop_cnt, s0_rdy_o); end
    tick();
    #1;
    vec_cnt++; if (grant !== 2'b01 || s1_rdy_o !== 1'b0 || m_data_o !== 32'h0F00_0000) begin err_cnt++; $display("FAIL orphan_grant got grant=%b s1rdy=%b data=%h exp 01/0/0f000000", grant, s1_rdy_o, m_data_o); end
    tick();
    s0_vld_i = 1'b0; s0_sof = 1'b0; s0_eof = 1'b0;
    #1;
    vec_cnt++; if (frame_cnt0 !== 4'd1 || drop_cnt !== 4'd3 || s1_rdy_o !== 1'b0 || grant !== 2'b00) begin err_cnt++; $display("FAIL orphan_end got f0=%0d drop=%0d s1rdy=%b grant=%b exp 1/3/0/00", frame_cnt0, drop_cnt, s1_rdy_o, grant); end
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    s0_vld_i = 1'b1; s0_sof = 1'b1; s0_data_i = 32'h7000_0000;
    tick();
    tick();  // beat 0 accepted
    s0_sof = 1'b0; s0_data_i = 32'h7000_0001;
    tick();  // beat 1 accepted
    s0_data_i = 32'h7000_0002;
    #1;
    vec_cnt++; if (s0_rdy_o !== 1'b1 || m_vld_o !== 1'b1) begin err_cnt++; $display("FAIL ares_pre got rdy=%b vld=%b exp 1/1", s0_rdy_o, m_vld_o); end
    #2 rst = 1'b1;
    #1;
    vec_cnt++; if (s0_rdy_o !== 1'b0 || m_vld_o !== 1'b0 || grant !== 2'b00) begin err_cnt++; $display("FAIL ares_drop got rdy=%b vld=%b grant=%b exp 0/0/00", s0_rdy_o, m_vld_o, grant); end
    vec_cnt++; if (frame_cnt0 !== 4'd0) begin err_cnt++; $display("FAIL ares_fcnt got %0d exp 0", frame_cnt0); end
    s0_data_i = 32'h7000_0003;
    #1 rst = 1'b0;
    tick();  // beat 3 dropped as orphan
    s0_eof = 1'b1; s0_data_i = 32'h7000_0004;
    tick();  // beat 4 dropped as orphan
    idle_inputs();
    #1;
    vec_cnt++; if (drop_cnt !== 4'd2 || frame_cnt0 !== 4'd0 || grant !== 2'b00) begin err_cnt++; $display("FAIL ares_after got drop=%0d f0=%0d grant=%b exp 2/0/00", drop_cnt, frame_cnt0, grant); end
  endtask

  task automatic test_wrap_single_beat();
    do_reset();
    src_en = 2'b01;
    s0_vld_i = 1'b1; s0_sof = 1'b1; s0_eof = 1'b1; s0_data_i = 32'h9999_9999;
    // each single-beat frame costs one arbitration cycle plus one granted cycle
    for (int i = 0; i < 30; i++) tick();
    vec_cnt++; if (frame_cnt0 !== 4'd15) begin err_cnt++; $display("FAIL wrap_15 got %0d exp 15", frame_cnt0); end
    tick(); tick();
    vec_cnt++; if (frame_cnt0 !== 4'd0) begin err_cnt++; $display("FAIL wrap_0 got %0d exp 0", frame_cnt0); end
    tick(); tick();
    vec_cnt++; if (frame_cnt0 !== 4'd1 || drop_cnt !== 4'd0) begin err_cnt++; $display("FAIL wrap_17 got f0=%0d drop=%0d exp 1/0", frame_cnt0, drop_cnt); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_both_requests();
    test_backpressure();
    test_orphans();
    test_async_reset();
    test_wrap_single_beat();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
